bitmon_sequencer: RTL and testbench

//  Sequences the transmit-side bit monitor of the CAN core. Tracks the frame phase of a frame

---
 rtl/bitmon_sequencer_if.sv | 30 +++
 rtl/bitmon_sequencer.sv | 138 +++++++++++++
 tb/tb_bitmon_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bitmon_sequencer_if.sv
// rtl/bitmon_sequencer_if.sv - TX MAC / bit-error comparator signal bundle for bitmon_sequencer
interface bitmon_sequencer_if;
    logic sample;
    logic tx_start;
    logic tx_bit;
    logic rx_bit;
    logic stuff_bit;
    logic crc_del;
    logic err_start;
    logic err_passive;
    logic err_end;
    logic activ;
    logic arb_lost;
    logic ack_ok;
    logic ack_err;
    logic tx_done;
    logic busy;

    modport master (
        output sample, tx_start, tx_bit, rx_bit, stuff_bit, crc_del,
               err_start, err_passive, err_end,
        input  activ, arb_lost, ack_ok, ack_err, tx_done, busy
    );

    modport slave (
        input  sample, tx_start, tx_bit, rx_bit, stuff_bit, crc_del,
               err_start, err_passive, err_end,
        output activ, arb_lost, ack_ok, ack_err, tx_done, busy
    );
endinterface

// File: rtl/bitmon_sequencer.sv
// rtl/bitmon_sequencer.sv - transmit frame-phase tracker driving the bit monitor enable
module bitmon_sequencer #(
    parameter int ID_BASE_BITS = 11,
    parameter int ID_EXT_BITS  = 18,
    parameter int EOF_BITS     = 7,
    parameter int CNT_W        = 6
) (
    input  logic               clock,
    input  logic               reset,
    bitmon_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_CTRL, S_ACK, S_ACKDEL, S_EOF, S_EFLAG
    } state_t;

    // cnt holds the index of the current arbitration bit, so these are bit positions
    localparam logic [CNT_W-1:0] IDE_POS  = CNT_W'(ID_BASE_BITS + 1);
    localparam logic [CNT_W-1:0] XRTR_POS = CNT_W'(ID_BASE_BITS + ID_EXT_BITS + 2);
    localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_BITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arb_lost_q, arb_lost_d;
    logic             ack_ok_q, ack_ok_d;
    logic             ack_err_q, ack_err_d;
    logic             tx_done_q, tx_done_d;
    logic             activ_c;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            arb_lost_q <= 1'b0;
            ack_ok_q   <= 1'b0;
            ack_err_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            arb_lost_q <= arb_lost_d;
            ack_ok_q   <= ack_ok_d;
            ack_err_q  <= ack_err_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        arb_lost_d = 1'b0;
        ack_ok_d   = 1'b0;
        ack_err_d  = 1'b0;
        tx_done_d  = 1'b0;
        activ_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                activ_c = bus.tx_start;
                if (bus.sample && bus.tx_start) begin
                    state_d = S_ARB;
                    cnt_d   = '0;
                end
            end
            S_ARB: begin
                // a recessive bit read back dominant is legal here unless it is a stuff bit
                activ_c = ~bus.tx_bit | bus.stuff_bit;
                if (bus.sample && !bus.stuff_bit) begin
                    if (bus.tx_bit && !bus.rx_bit) begin
                        arb_lost_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if ((cnt_q == IDE_POS && !bus.tx_bit) || cnt_q == XRTR_POS) begin
                            state_d = S_CTRL;
                        end
                    end
                end
            end
            S_CTRL: begin
                activ_c = 1'b1;
                if (bus.sample && bus.crc_del) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                activ_c = 1'b0;
                if (bus.sample) begin
                    ack_ok_d  = ~bus.rx_bit;
                    ack_err_d = bus.rx_bit;
                    state_d   = S_ACKDEL;
                end
            end
            S_ACKDEL: begin
                activ_c = 1'b1;
                if (bus.sample) begin
                    state_d = S_EOF;
                    cnt_d   = '0;
                end
            end
            S_EOF: begin
                activ_c = 1'b1;
                if (bus.sample) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == EOF_LAST) begin
                        tx_done_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_EFLAG: begin
                activ_c = ~bus.err_passive;
                if (bus.sample && bus.err_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // an own error flag overrides whatever the frame phase would have done
        if (bus.sample && bus.err_start) begin
            state_d    = S_EFLAG;
            cnt_d      = '0;
            arb_lost_d = 1'b0;
            ack_ok_d   = 1'b0;
            ack_err_d  = 1'b0;
            tx_done_d  = 1'b0;
        end
    end

    assign bus.activ    = activ_c;
    assign bus.arb_lost = arb_lost_q;
    assign bus.ack_ok   = ack_ok_q;
    assign bus.ack_err  = ack_err_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_bitmon_sequencer.sv
// tb/tb_bitmon_sequencer.sv - directed self-checking bench for bitmon_sequencer
module tb_bitmon_sequencer;
    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    bitmon_sequencer_if bus ();

    bitmon_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_ARB  = 4'b1000;
    localparam logic [3:0] P_AOK  = 4'b0100;
    localparam logic [3:0] P_AERR = 4'b0010;
    localparam logic [3:0] P_DONE = 4'b0001;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {bus.arb_lost, bus.ack_ok, bus.ack_err, bus.tx_done};
    endfunction

    // one bit time: drive, check activ before the edge, check pulses/busy after it
    task automatic step(input logic smp, input logic tx, input logic rx, input logic stf,
                        input logic crc, input logic es, input logic ee, input logic ea,
                        input logic [3:0] ep, input logic eb, input string tag);
        bus.sample    = smp;
        bus.tx_bit    = tx;
        bus.rx_bit    = rx;
        bus.stuff_bit = stf;
        bus.crc_del   = crc;
        bus.err_start = es;
        bus.err_end   = ee;
        #1;
        chk({tag, ":activ"}, {3'b000, bus.activ}, {3'b000, ea});
        @(posedge clock);
        #1;
        chk({tag, ":pulses"}, pulses(), ep);
        chk({tag, ":busy"}, {3'b000, bus.busy}, {3'b000, eb});
        bus.sample    = 1'b0;
        bus.stuff_bit = 1'b0;
        bus.crc_del   = 1'b0;
        bus.err_start = 1'b0;
        bus.err_end   = 1'b0;
    endtask

    task automatic sof(input string tag);
        bus.tx_start = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0, 1, P_NONE, 1, tag);
        bus.tx_start = 1'b0;
    endtask

    // ID 0x123, RTR=0, IDE=0: leaves ARB after position 12
    task automatic std_arb(input string tag);
        logic [12:0] arb;
        arb = {11'h123, 1'b0, 1'b0};
        for (int i = 12; i >= 0; i--) begin
            step(1, arb[i], arb[i], 0, 0, 0, 0, ~arb[i], P_NONE, 1, tag);
        end
    endtask

    task automatic frame_tail(input logic ack_rx, input logic [3:0] ack_p, input string tag);
        step(1, 1, 1, 0, 0, 0, 0, 1, P_NONE, 1, {tag, "_ctrl"});
        step(1, 1, 1, 0, 1, 0, 0, 1, P_NONE, 1, {tag, "_crcdel"});
        step(1, 1, ack_rx, 0, 0, 0, 0, 0, ack_p, 1, {tag, "_ack"});
        step(1, 1, 1, 0, 0, 0, 0, 1, P_NONE, 1, {tag, "_ackdel"});
        for (int i = 0; i < 7; i++) begin
            step(1, 1, 1, 0, 0, 0, 0, 1, (i == 6) ? P_DONE : P_NONE, (i != 6), {tag, "_eof"});
        end
        step(1, 1, 1, 0, 0, 0, 0, 0, P_NONE, 0, {tag, "_idle"});
    endtask

    initial begin
        logic [31:0] ext;
        reset           = 1'b0;
        bus.sample      = 1'b0;
        bus.tx_start    = 1'b0;
        bus.tx_bit      = 1'b1;
        bus.rx_bit      = 1'b1;
        bus.stuff_bit   = 1'b0;
        bus.crc_del     = 1'b0;
        bus.err_start   = 1'b0;
        bus.err_passive = 1'b0;
        bus.err_end     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset:pulses", pulses(), P_NONE);
        chk("reset:busy", {3'b000, bus.busy}, 4'b0000);
        chk("reset:activ", {3'b000, bus.activ}, 4'b0000);
        reset = 1'b1;

        // standard frame, clean arbitration, dominant ACK
        sof("t1_sof");
        step(0, 1, 0, 0, 0, 0, 0, 0, P_NONE, 1, "t1_nosample");
        std_arb("t1_arb");
        frame_tail(1'b0, P_AOK, "t1");

        // arbitration lost on a recessive ID bit
        sof("t2_sof");
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 1, P_NONE, 1, "t2_arb");
        end
        step(1, 1, 0, 0, 0, 0, 0, 0, P_ARB, 0, "t2_lost");
        for (int i = 0; i < 12; i++) begin
            step(1, 1, i[0], 0, 0, 0, 0, 0, P_NONE, 0, "t2_after");
        end

        // extended frame with stuff bits, then a recessive ACK slot
        ext = {11'h123, 1'b1, 1'b1, 18'h2B6D7, 1'b0};
        sof("t3_sof");
        for (int i = 31; i >= 0; i--) begin
            step(1, ext[i], ext[i], 0, 0, 0, 0, ~ext[i], P_NONE, 1, "t3_arb");
            if (i == 26) step(1, 0, 0, 1, 0, 0, 0, 1, P_NONE, 1, "t3_stuff_dom");
            if (i == 11) step(1, 1, 0, 1, 0, 0, 0, 1, P_NONE, 1, "t3_stuff_rec");
        end
        frame_tail(1'b1, P_AERR, "t4");

        // error flag from CTRL, active then passive
        sof("t5_sof");
        std_arb("t5_arb");
        step(1, 0, 0, 0, 0, 1, 0, 1, P_NONE, 1, "t5_errstart");
        step(1, 0, 0, 0, 0, 0, 0, 1, P_NONE, 1, "t5_eflag_act");
        bus.err_passive = 1'b1;
        step(1, 1, 1, 0, 0, 0, 0, 0, P_NONE, 1, "t5_eflag_pas");
        step(1, 1, 1, 0, 0, 0, 1, 0, P_NONE, 0, "t5_errend");
        bus.err_passive = 1'b0;

        // error flag on the same sample as an arbitration loss
        sof("t5b_sof");
        step(1, 0, 0, 0, 0, 0, 0, 1, P_NONE, 1, "t5b_arb");
        step(1, 1, 0, 0, 0, 1, 0, 0, P_NONE, 1, "t5b_err_lost");
        step(1, 0, 0, 0, 0, 0, 0, 1, P_NONE, 1, "t5b_eflag");
        step(1, 1, 1, 0, 0, 0, 1, 1, P_NONE, 0, "t5b_errend");

        // reset during EOF bit 3
        sof("t6_sof");
        std_arb("t6_arb");
        step(1, 1, 1, 0, 1, 0, 0, 1, P_NONE, 1, "t6_crcdel");
        step(1, 1, 0, 0, 0, 0, 0, 0, P_AOK, 1, "t6_ack");
        step(1, 1, 1, 0, 0, 0, 0, 1, P_NONE, 1, "t6_ackdel");
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0, 0, 0, 0, 1, P_NONE, 1, "t6_eof");
        end
        reset = 1'b0;
        step(1, 1, 1, 0, 0, 0, 0, 1, P_NONE, 0, "t6_reset");
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 0, 0, 0, 0, 0, P_NONE, 0, "t6_after");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
